bus_stim_seq: RTL

Programmable bus stimulus sequencer that replays a table of up to DEPTH beats as `en`/`wr`/`addr`/`wdata` on successive rising clock edges. It replaces hand-coded stimulus tasks with a synthesizable engine. The engine adds a ready/stall handshake, one-shot or loop mode, and abort. It sits between the bench or config master and the memory-style target under test.

---
 rtl/bus_stim_pkg.sv | 17 +
 rtl/bus_stim_table.sv | 63 ++++++
 rtl/bus_stim_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/bus_stim_pkg.sv
// rtl/bus_stim_pkg.sv - shared types and default widths for the bus stimulus sequencer
//
// Purpose : sequencer state encoding and default parameter values.
// Contents: stim_state_t (IDLE/RUN/DONE), STIM_ADDR_W, STIM_DATA_W, STIM_DEPTH.
package bus_stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stim_state_t;

    localparam int STIM_ADDR_W = 6;
    localparam int STIM_DATA_W = 8;
    localparam int STIM_DEPTH  = 8;

endpackage

// File: rtl/bus_stim_table.sv
// rtl/bus_stim_table.sv - beat table register file for the bus stimulus sequencer
//
// Purpose : DEPTH entries of {wr, addr, data}; cleared by reset, one write
//           port, one combinational read port.
// Ports   : i_clk, i_rst          clock, async active-high reset
//           i_we, i_widx          write strobe and entry index
//           i_wr, i_addr, i_data  entry contents to write
//           i_ridx                read index
//           o_wr, o_addr, o_data  entry at i_ridx
module bus_stim_table
    import bus_stim_pkg::*;
#(
    parameter int ADDR_W = STIM_ADDR_W,
    parameter int DATA_W = STIM_DATA_W,
    parameter int DEPTH  = STIM_DEPTH,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_widx,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic [IDX_W-1:0]  i_ridx,
    output logic              o_wr,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data
);

    logic [DEPTH-1:0]  r_wr;
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic              w_idx_ok;

    // Indices beyond the last entry only exist when DEPTH is not a power of two.
    generate
        if (DEPTH == (1 << IDX_W)) begin : g_full_range
            assign w_idx_ok = 1'b1;
        end else begin : g_part_range
            assign w_idx_ok = (32'(i_widx) < DEPTH);
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else if (i_we && w_idx_ok) begin
            r_wr[i_widx]   <= i_wr;
            r_addr[i_widx] <= i_addr;
            r_data[i_widx] <= i_data;
        end
    end

    assign o_wr   = r_wr[i_ridx];
    assign o_addr = r_addr[i_ridx];
    assign o_data = r_data[i_ridx];

endmodule

// File: rtl/bus_stim_seq.sv
// rtl/bus_stim_seq.sv - programmable bus stimulus sequencer top
//
// Purpose : replays up to DEPTH table beats as en/wr/addr/wdata with a
//           ready handshake, one-shot or loop mode and a sticky stop.
// Ports   : i_clk, i_rst                          clock, async active-high reset
//           i_cfg_we, i_cfg_idx                   table write strobe / entry (IDLE only)
//           i_cfg_wr, i_cfg_addr, i_cfg_data      table entry contents
//           i_cfg_len                             beats per pass, latched at start
//           i_start, i_loop_mode, i_stop          sequence control
//           i_ready                               target accepts presented beat
//           o_en, o_wr, o_addr, o_wdata           registered beat outputs
//           o_busy                                high while in RUN
//           o_done                                one-cycle pulse on natural completion
module bus_stim_seq
    import bus_stim_pkg::*;
#(
    parameter int ADDR_W = STIM_ADDR_W,
    parameter int DATA_W = STIM_DATA_W,
    parameter int DEPTH  = STIM_DEPTH,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int LEN_W  = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cfg_we,
    input  logic [IDX_W-1:0]  i_cfg_idx,
    input  logic              i_cfg_wr,
    input  logic [ADDR_W-1:0] i_cfg_addr,
    input  logic [DATA_W-1:0] i_cfg_data,
    input  logic [LEN_W-1:0]  i_cfg_len,
    input  logic              i_start,
    input  logic              i_loop_mode,
    input  logic              i_stop,
    input  logic              i_ready,
    output logic              o_en,
    output logic              o_wr,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_busy,
    output logic              o_done
);

    stim_state_t       r_state;
    stim_state_t       w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  w_len_start;
    logic              r_loop;
    logic              r_stop_req;

    logic              r_en;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_en_nxt;
    logic              w_wr_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_wdata_nxt;

    logic              w_accept;
    logic              w_last;
    logic              w_stop_now;
    logic              w_tbl_we;
    logic              w_tbl_wr;
    logic [ADDR_W-1:0] w_tbl_addr;
    logic [DATA_W-1:0] w_tbl_data;

    // Table is only writable while idle so a running pass sees a stable table.
    assign w_tbl_we = i_cfg_we && (r_state == IDLE);

    bus_stim_table #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_table (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_we   (w_tbl_we),
        .i_widx (i_cfg_idx),
        .i_wr   (i_cfg_wr),
        .i_addr (i_cfg_addr),
        .i_data (i_cfg_data),
        .i_ridx (w_idx_nxt),
        .o_wr   (w_tbl_wr),
        .o_addr (w_tbl_addr),
        .o_data (w_tbl_data)
    );

    // Lengths above DEPTH would walk the index past the table; clamp them.
    assign w_len_start = (i_cfg_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : i_cfg_len;

    assign w_accept   = (r_state == RUN) && r_en && i_ready;
    assign w_last     = (LEN_W'(r_idx) == (r_len - LEN_W'(1)));
    // A stop arriving on the accepting edge itself counts the same as a sticky one.
    assign w_stop_now = r_stop_req || i_stop;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = (w_len_start == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_accept) begin
                    if (w_stop_now) begin
                        w_state_nxt = IDLE;
                    end else if (w_last && !r_loop) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output logic: next index and the beat to present after this edge.
    // While stalled the index holds, so reloading from the (frozen) table
    // reproduces the current beat.
    always_comb begin
        w_idx_nxt = '0;
        if (r_state == RUN) begin
            if (w_accept) begin
                w_idx_nxt = w_last ? '0 : (r_idx + IDX_W'(1));
            end else begin
                w_idx_nxt = r_idx;
            end
        end
        w_en_nxt    = (w_state_nxt == RUN);
        w_wr_nxt    = w_en_nxt && w_tbl_wr;
        w_addr_nxt  = w_en_nxt ? w_tbl_addr : '0;
        w_wdata_nxt = w_en_nxt ? w_tbl_data : '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx      <= '0;
            r_len      <= '0;
            r_loop     <= 1'b0;
            r_stop_req <= 1'b0;
            r_en       <= 1'b0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_idx   <= w_idx_nxt;
            r_en    <= w_en_nxt;
            r_wr    <= w_wr_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;

            if ((r_state == IDLE) && i_start) begin
                r_len  <= w_len_start;
                r_loop <= i_loop_mode;
            end

            if (w_state_nxt != RUN) begin
                r_stop_req <= 1'b0;
            end else if ((r_state == RUN) && i_stop) begin
                r_stop_req <= 1'b1;
            end
        end
    end

    assign o_en    = r_en;
    assign o_wr    = r_wr;
    assign o_addr  = r_addr;
    assign o_wdata = r_wdata;
    assign o_busy  = (r_state == RUN);
    assign o_done  = (r_state == DONE);

endmodule
